// File: rtl/bps_core.sv
// bps_core: single-chain TRW-S min-sum engine with Potts sweeps and bulk memory load/store
module bps_core #(
  parameter int LABELS = 16,
  parameter int MSG_W = 6,
  parameter int NODES = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      stall,
  input  logic [2:0]                opcode,
  input  logic [63:0]               addr_base,
  output logic                      mc_req_ld,
  output logic                      mc_req_st,
  output logic [47:0]               mc_req_vadr,
  output logic [63:0]               mc_req_wrd_rdctl,
  input  logic                      mc_req_stall,
  input  logic [31:0]               mc_rsp_rdctl,
  input  logic [63:0]               mc_rsp_data,
  input  logic                      mc_rsp_push,
  output logic                      mc_rsp_stall,
  input  logic [LABELS*MSG_W-1:0]   up_in,
  output logic [LABELS*MSG_W-1:0]   up_out,
  input  logic [LABELS*MSG_W-1:0]   down_in,
  output logic [LABELS*MSG_W-1:0]   down_out
);
  localparam int VW = LABELS * MSG_W;
  localparam int NLD = 5 + 2 * NODES;
  localparam int NST = 2 * NODES;
  localparam int CW = $clog2(NLD + 1);
  localparam int NW = NODES > 1 ? $clog2(NODES) : 1;
  typedef enum logic [2:0] {IDLE, LOAD_REQ, LOAD_WAIT, SWEEP_DN, SWEEP_UP, STORE_REQ} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, rcnt;
  logic [47:0] base;
  logic [MSG_W-1:0] lambda;
  logic [VW-1:0] m, step, belief;
  logic [VW-1:0] unary [NODES];
  logic [VW-1:0] dmsg [NODES];
  logic [VW-1:0] umsg [NODES];
  logic [NW-1:0] nidx, ridx;
  logic [31:0] roff;
  logic issue, sweep, sweep_end, rsp_ok, rsp_un;
  logic unused;

  function automatic logic [VW-1:0] sat_add(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [MSG_W:0] s;
    sat_add = '0;
    for (int l = 0; l < LABELS; l++) begin
      s = {1'b0, a[l*MSG_W +: MSG_W]} + {1'b0, b[l*MSG_W +: MSG_W]};
      sat_add[l*MSG_W +: MSG_W] = s[MSG_W] ? '1 : s[MSG_W-1:0];
    end
  endfunction

  // Normalise so the smallest entry is 0, then truncate at lambda.
  function automatic logic [VW-1:0] potts(input logic [VW-1:0] h, input logic [MSG_W-1:0] lam);
    logic [MSG_W-1:0] mn, d;
    mn = '1;
    potts = '0;
    for (int l = 0; l < LABELS; l++) mn = h[l*MSG_W +: MSG_W] < mn ? h[l*MSG_W +: MSG_W] : mn;
    for (int l = 0; l < LABELS; l++) begin
      d = h[l*MSG_W +: MSG_W] - mn;
      potts[l*MSG_W +: MSG_W] = d < lam ? d : lam;
    end
  endfunction

  assign mc_rsp_stall = 1'b0;
  assign unused = ^addr_base[63:48];
  assign sweep = state == SWEEP_DN || state == SWEEP_UP;
  assign sweep_end = cnt == CW'(NODES);
  assign issue = !mc_req_stall && (state == LOAD_REQ || state == STORE_REQ);
  assign rsp_ok = mc_rsp_push && (state == LOAD_REQ || state == LOAD_WAIT);
  assign roff = mc_rsp_rdctl - 32'd5;
  assign rsp_un = mc_rsp_rdctl >= 32'd5 && mc_rsp_rdctl < 32'(NLD);
  assign ridx = NW'(roff >> 1);
  assign nidx = state == SWEEP_UP ? NW'(NODES - 1 - int'(cnt)) : state == STORE_REQ ? NW'(cnt >> 1) : NW'(cnt);
  assign step = potts(sat_add(unary[nidx], m), lambda);
  assign belief = sat_add(sat_add(unary[nidx], dmsg[nidx]), umsg[nidx]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = opcode == 3'd1 ? LOAD_REQ : opcode == 3'd2 ? SWEEP_DN :
                       opcode == 3'd3 ? SWEEP_UP : opcode == 3'd4 ? STORE_REQ : IDLE;
      LOAD_REQ: state_nx = issue && cnt == CW'(NLD - 1) ? LOAD_WAIT : LOAD_REQ;
      LOAD_WAIT: state_nx = rcnt == CW'(NLD) ? IDLE : LOAD_WAIT;
      SWEEP_DN, SWEEP_UP: state_nx = sweep_end ? IDLE : state;
      STORE_REQ: state_nx = issue && cnt == CW'(NST - 1) ? IDLE : STORE_REQ;
      default: state_nx = IDLE;
    endcase
  end

  // Belief words follow the unary block; the second word of a pair carries the top 32 bits.
  always_comb begin
    mc_req_ld = state == LOAD_REQ && !mc_req_stall;
    mc_req_st = state == STORE_REQ && !mc_req_stall;
    mc_req_vadr = mc_req_ld ? base + (48'(cnt) << 3) :
                  mc_req_st ? base + ((48'(cnt) + 48'(NLD)) << 3) : '0;
    mc_req_wrd_rdctl = mc_req_ld ? 64'(cnt) :
                       mc_req_st ? (cnt[0] ? 64'(belief[VW-1:64]) : belief[63:0]) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall <= 1'b0;
      cnt <= '0;
      rcnt <= '0;
      base <= '0;
      lambda <= '0;
      m <= '0;
      up_out <= '0;
      down_out <= '0;
    end else begin
      stall <= state_nx != IDLE;
      if (state == IDLE) begin
        cnt <= '0;
        rcnt <= '0;
        base <= addr_base[47:0];
        m <= opcode == 3'd3 ? up_in : down_in;
      end else if (issue || (sweep && !sweep_end)) cnt <= cnt + 1'b1;
      if (rsp_ok) rcnt <= rcnt + 1'b1;
      if (rsp_ok && mc_rsp_rdctl == 32'd0) lambda <= mc_rsp_data[MSG_W-1:0];
      if (sweep && !sweep_end) m <= step;
      if (state == SWEEP_DN && sweep_end) down_out <= m;
      if (state == SWEEP_UP && sweep_end) up_out <= m;
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_ok && rsp_un && roff[0]) unary[ridx][VW-1:64] <= mc_rsp_data[VW-65:0];
    if (rsp_ok && rsp_un && !roff[0]) unary[ridx][63:0] <= mc_rsp_data;
    if (state == SWEEP_DN && !sweep_end) dmsg[nidx] <= m;
    if (state == SWEEP_UP && !sweep_end) umsg[nidx] <= m;
  end
endmodule

// File: tb/tb_bps_core.sv
// tb_bps_core: randomized self-checking bench for bps_core against a label-level reference model
module tb_bps_core;
  localparam int N = 2;
  localparam int L = 16;
  localparam int W = 6;
  localparam int NLD = 5 + 2 * N;
  localparam int NST = 2 * N;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall;
  logic [2:0] opcode = '0;
  logic [63:0] addr_base = '0;
  logic mc_req_ld, mc_req_st, mc_rsp_stall;
  logic [47:0] mc_req_vadr;
  logic [63:0] mc_req_wrd_rdctl;
  logic mc_req_stall = 1'b0;
  logic [31:0] mc_rsp_rdctl = '0;
  logic [63:0] mc_rsp_data = '0;
  logic mc_rsp_push = 1'b0;
  logic [95:0] up_in = '0, down_in = '0, up_out, down_out;
  int checks = 0, passes = 0;
  logic [63:0] mem [NLD];
  logic [95:0] r_un [N];
  logic [95:0] r_dm [N];
  logic [95:0] r_um [N];
  logic [95:0] r_dout = '0, r_uout = '0;
  int r_lam;

  always #5 clk = ~clk;

  bps_core #(.LABELS(L), .MSG_W(W), .NODES(N)) dut (
    .clk(clk), .rst(rst), .stall(stall), .opcode(opcode), .addr_base(addr_base),
    .mc_req_ld(mc_req_ld), .mc_req_st(mc_req_st), .mc_req_vadr(mc_req_vadr),
    .mc_req_wrd_rdctl(mc_req_wrd_rdctl), .mc_req_stall(mc_req_stall),
    .mc_rsp_rdctl(mc_rsp_rdctl), .mc_rsp_data(mc_rsp_data), .mc_rsp_push(mc_rsp_push),
    .mc_rsp_stall(mc_rsp_stall), .up_in(up_in), .up_out(up_out),
    .down_in(down_in), .down_out(down_out)
  );

  function automatic logic [95:0] splat(input int v);
    for (int l = 0; l < L; l++) splat[l*W +: W] = W'(v);
  endfunction

  function automatic logic [95:0] rand_vec();
    for (int l = 0; l < L; l++) rand_vec[l*W +: W] = W'($urandom_range(0, 63));
  endfunction

  // One message-passing step: add unary to incoming message, clamp, subtract min, cap at lambda.
  function automatic logic [95:0] ref_step(input logic [95:0] u, input logic [95:0] msg, input int lam);
    int h [L];
    int mn;
    mn = 1000;
    for (int l = 0; l < L; l++) begin
      h[l] = int'(u[l*W +: W]) + int'(msg[l*W +: W]);
      if (h[l] > 63) h[l] = 63;
      if (h[l] < mn) mn = h[l];
    end
    for (int l = 0; l < L; l++) ref_step[l*W +: W] = W'((h[l] - mn) < lam ? (h[l] - mn) : lam);
  endfunction

  function automatic logic [95:0] ref_belief(input int i);
    int s;
    for (int l = 0; l < L; l++) begin
      s = int'(r_un[i][l*W +: W]) + int'(r_dm[i][l*W +: W]) + int'(r_um[i][l*W +: W]);
      ref_belief[l*W +: W] = W'(s > 63 ? 63 : s);
    end
  endfunction

  task automatic pack_mem();
    mem[0] = 64'(r_lam);
    for (int w = 1; w < 5; w++) mem[w] = {$urandom, $urandom};
    for (int i = 0; i < N; i++) begin
      mem[5 + 2*i] = r_un[i][63:0];
      mem[6 + 2*i] = {32'h0, r_un[i][95:64]};
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else passes++;
    checks++; if ({mc_req_ld, mc_req_st} !== 2'b00) $display("FAIL reset_req got %b want 00", {mc_req_ld, mc_req_st}); else passes++;
    checks++; if (up_out !== '0) $display("FAIL reset_up_out got %h want 0", up_out); else passes++;
    checks++; if (down_out !== '0) $display("FAIL reset_down_out got %h want 0", down_out); else passes++;
    checks++; if (mc_rsp_stall !== 1'b0) $display("FAIL reset_rsp_stall got %b want 0", mc_rsp_stall); else passes++;
  endtask

  task automatic test_load(input bit rev, input bit tog);
    int pend[$];
    int nreq, lat, t;
    bit st;
    nreq = 0; lat = -1; st = 1'b0;
    @(negedge clk); opcode = 3'd1;
    @(negedge clk); opcode = 3'd0;
    for (int k = 0; k < 500 && lat < 0; k++) begin
      if (k > 0) @(negedge clk);
      mc_rsp_push = 1'b0;
      if (pend.size() > 0 && (!rev || nreq == NLD)) begin
        t = rev ? pend.pop_back() : pend.pop_front();
        mc_rsp_push = 1'b1;
        mc_rsp_rdctl = 32'(t);
        mc_rsp_data = mem[t];
      end
      mc_req_stall = tog & st;
      st = !st;
      #1;
      if (!stall) lat = k;
      if (mc_req_ld) begin
        checks++; if (mc_req_stall || mc_req_st) $display("FAIL load_req_excl got stall=%b st=%b want 0 0", mc_req_stall, mc_req_st); else passes++;
        checks++; if (mc_req_vadr !== 48'(addr_base + 64'(8 * nreq))) $display("FAIL load_addr got %h want %h", mc_req_vadr, 48'(addr_base + 64'(8 * nreq))); else passes++;
        checks++; if (mc_req_wrd_rdctl !== 64'(nreq)) $display("FAIL load_tag got %0d want %0d", mc_req_wrd_rdctl, nreq); else passes++;
        if (nreq < NLD) pend.push_back(nreq);
        nreq++;
      end
    end
    mc_rsp_push = 1'b0;
    mc_req_stall = 1'b0;
    checks++; if (nreq != NLD) $display("FAIL load_count got %0d want %0d", nreq, NLD); else passes++;
    checks++;
    if ((rev || tog) ? lat < 0 : lat != NLD + 2) $display("FAIL load_latency got %0d want %0d", lat, NLD + 2);
    else passes++;
  endtask

  task automatic test_sweep(input bit up, input logic [95:0] min_v);
    logic [95:0] msg;
    int lat;
    msg = min_v;
    if (!up) begin
      for (int i = 0; i < N; i++) begin r_dm[i] = msg; msg = ref_step(r_un[i], msg, r_lam); end
      r_dout = msg;
    end else begin
      for (int i = N - 1; i >= 0; i--) begin r_um[i] = msg; msg = ref_step(r_un[i], msg, r_lam); end
      r_uout = msg;
    end
    @(negedge clk);
    opcode = up ? 3'd3 : 3'd2;
    if (up) up_in = min_v; else down_in = min_v;
    @(negedge clk);
    opcode = 3'd0;
    up_in = rand_vec();
    down_in = rand_vec();
    lat = -1;
    for (int k = 0; k < 50 && lat < 0; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (!stall) lat = k;
    end
    checks++; if (lat != N + 1) $display("FAIL sweep_latency got %0d want %0d", lat, N + 1); else passes++;
    checks++; if (down_out !== r_dout) $display("FAIL sweep_down_out got %h want %h", down_out, r_dout); else passes++;
    checks++; if (up_out !== r_uout) $display("FAIL sweep_up_out got %h want %h", up_out, r_uout); else passes++;
  endtask

  task automatic test_store(input bit tog);
    int n, lat;
    bit st;
    logic [95:0] b;
    logic [63:0] want;
    n = 0; lat = -1; st = 1'b0;
    @(negedge clk); opcode = 3'd4;
    @(negedge clk); opcode = 3'd0;
    for (int k = 0; k < 200 && lat < 0; k++) begin
      if (k > 0) @(negedge clk);
      mc_req_stall = tog & st;
      st = !st;
      #1;
      if (!stall) lat = k;
      if (mc_req_st) begin
        b = ref_belief(n / 2);
        want = n[0] ? {32'h0, b[95:64]} : b[63:0];
        checks++; if (mc_req_stall || mc_req_ld) $display("FAIL store_req_excl got stall=%b ld=%b want 0 0", mc_req_stall, mc_req_ld); else passes++;
        checks++; if (mc_req_vadr !== 48'(addr_base + 64'(8 * (NLD + n)))) $display("FAIL store_addr got %h want %h", mc_req_vadr, 48'(addr_base + 64'(8 * (NLD + n)))); else passes++;
        checks++; if (mc_req_wrd_rdctl !== want) $display("FAIL store_data got %h want %h", mc_req_wrd_rdctl, want); else passes++;
        n++;
      end
    end
    mc_req_stall = 1'b0;
    checks++; if (n != NST) $display("FAIL store_count got %0d want %0d", n, NST); else passes++;
    checks++;
    if (tog ? lat < 0 : lat != NST) $display("FAIL store_latency got %0d want %0d", lat, NST);
    else passes++;
  endtask

  task automatic test_directed();
    logic [95:0] v;
    addr_base = '0;
    r_lam = 10;
    v = splat(20);
    v[3*W +: W] = 6'd0;
    r_un[0] = v;
    r_un[1] = '0;
    pack_mem();
    test_load(1'b0, 1'b0);
    test_sweep(1'b0, '0);
    v = splat(10);
    v[3*W +: W] = 6'd0;
    checks++; if (down_out !== v) $display("FAIL directed_down got %h want %h", down_out, v); else passes++;
    v = splat(63);
    v[0 +: W] = 6'd0;
    test_sweep(1'b1, v);
    v = splat(10);
    v[3*W +: W] = 6'd0;
    checks++; if (up_out !== v) $display("FAIL directed_up got %h want %h", up_out, v); else passes++;
    test_store(1'b0);
  endtask

  task automatic test_mid_reset();
    @(negedge clk); opcode = 3'd1;
    @(negedge clk); opcode = 3'd0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) $display("FAIL midrst_stall got %b want 0", stall); else passes++;
    checks++; if (mc_req_ld !== 1'b0) $display("FAIL midrst_ld got %b want 0", mc_req_ld); else passes++;
    checks++; if (down_out !== '0 || up_out !== '0) $display("FAIL midrst_outs got %h %h want 0 0", down_out, up_out); else passes++;
    @(negedge clk); rst = 1'b0;
    r_dout = '0;
    r_uout = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (stall !== 1'b0 || mc_req_ld !== 1'b0) $display("FAIL midrst_idle got stall=%b ld=%b want 0 0", stall, mc_req_ld); else passes++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      addr_base = {$urandom, $urandom} & ~64'h7;
      r_lam = $urandom_range(0, 63);
      for (int i = 0; i < N; i++) r_un[i] = rand_vec();
      pack_mem();
      test_load(1'b0, 1'b0);
      test_sweep(1'b0, rand_vec());
      test_sweep(1'b1, rand_vec());
      test_store(1'b0);
    end
  endtask

  task automatic test_ooo_stall();
    addr_base = {$urandom, $urandom} & ~64'h7;
    r_lam = $urandom_range(1, 63);
    for (int i = 0; i < N; i++) r_un[i] = rand_vec();
    pack_mem();
    test_load(1'b1, 1'b1);
    test_sweep(1'b0, rand_vec());
    test_sweep(1'b1, rand_vec());
    test_store(1'b1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mid_reset();
    test_random();
    test_ooo_stall();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
